mvm_sequencer: RTL

Controller that sequences the vector-scalar MAC array (`vsm`, SIZE lanes of 8-bit `mac`) through one matrix-vector multiply job. It reads up to K_MAX (column, scalar) pairs from an operand memory and clears the accumulators before the job. It presents the pairs to the array, lets the last product settle, and captures the SIZE lane results into a held result register with a valid/ready handshake. It sits between the job-issuing logic and the `vsm` instance, and owns the array's clear.

---
 rtl/mvm_pkg.sv | 23 ++
 rtl/mvm_result_reg.sv | 59 +++++
 rtl/mvm_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// mvm_pkg: shared types and constants for the MVM sequencer.
// Holds the FSM state enum, lane width and default array geometry.
package mvm_pkg;

  localparam int LANE_W    = 8;
  localparam int SIZE_DEF  = 6;
  localparam int K_MAX_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_WAIT,
    S_RESULT
  } state_t;

  function automatic logic [LANE_W-1:0] relu8(
    input logic [LANE_W-1:0] x
  );
    return x[LANE_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/mvm_result_reg.sv
// mvm_result_reg: captures the array lanes and holds them with valid/ready.
// Define MVM_SEQ_RELU_EN to clamp negative lanes to zero at capture.
module mvm_result_reg
  import mvm_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture,
  input  logic                   accept,
  input  logic [LANE_W*SIZE-1:0] din,
  output logic [LANE_W*SIZE-1:0] res_data,
  output logic                   res_valid
);

  logic [LANE_W*SIZE-1:0] data_q;
  logic [LANE_W*SIZE-1:0] data_d;
  logic [LANE_W*SIZE-1:0] lanes;
  logic                   valid_q;
  logic                   valid_d;

  // Per-lane transform applied at capture time
  always_comb begin
    lanes = din;
`ifdef MVM_SEQ_RELU_EN
    for (int i = 0; i < SIZE; i++) begin
      lanes[LANE_W*i +: LANE_W] = relu8(din[LANE_W*i +: LANE_W]);
    end
`endif
  end

  // Load on capture, drop valid on handshake, otherwise hold
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (capture) begin
      data_d  = lanes;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // Result register state
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign res_data  = data_q;
  assign res_valid = valid_q;

endmodule

// File: rtl/mvm_sequencer.sv
// mvm_sequencer: sequences the vsm MAC array through one MVM job.
// Optional build macro MVM_SEQ_RELU_EN enables ReLU on captured lanes.
module mvm_sequencer
  import mvm_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int K_MAX  = K_MAX_DEF,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  output logic                   busy,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [LANE_W*SIZE-1:0] mem_a_rdata,
  input  logic [LANE_W-1:0]      mem_b_rdata,
  output logic                   vsm_reset,
  output logic [LANE_W*SIZE-1:0] vsm_a,
  output logic [LANE_W-1:0]      vsm_b,
  input  logic [LANE_W*SIZE-1:0] vsm_out,
  output logic [LANE_W*SIZE-1:0] res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   done
);

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic             settle_q;
  logic             settle_d;
  logic             rd_valid_q;
  logic             rd_valid_d;
  logic             capture;
  logic             accept;

  // State register and job bookkeeping flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      settle_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state: clamp length at accept, walk addresses, settle once
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    rd_valid_d = (state_q == S_RUN);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          len_d   = (len > LEN_W'(K_MAX)) ? LEN_W'(K_MAX) : len;
        end
      end
      S_CLEAR: begin
        cnt_d    = '0;
        settle_d = 1'b0;
        state_d  = (len_q != '0) ? S_RUN : S_WAIT;
      end
      S_RUN: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        settle_d = 1'b1;
        if (settle_q) begin
          settle_d = 1'b0;
          state_d  = S_RESULT;
        end
      end
      S_RESULT: begin
        if (accept) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: read strobe, forwarded operands, array clear, handshake
  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_rd_en = (state_q == S_RUN);
    mem_addr  = mem_rd_en ? ADDR_W'(cnt_q) : '0;
    vsm_reset = reset | (state_q == S_CLEAR);
    vsm_a     = '0;
    vsm_b     = '0;
    if (rd_valid_q && !reset) begin
      vsm_a = mem_a_rdata;
      vsm_b = mem_b_rdata;
    end
    capture = (state_q == S_WAIT) && settle_q;
    accept  = (state_q == S_RESULT) && res_valid && res_ready;
    done    = accept;
  end

  mvm_result_reg #(
    .SIZE (SIZE)
  ) u_res (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .accept    (accept),
    .din       (vsm_out),
    .res_data  (res_data),
    .res_valid (res_valid)
  );

endmodule
